// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM (IF/ID/EXE/MEM/WB) with retired-instruction counter.
// Optional memory wait states are enabled by defining MCTRL_MEMWAIT_EN, which adds the mem_rdy port.
module multicycle_ctrl #(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       op,
    input  logic             zero,
`ifdef MCTRL_MEMWAIT_EN
    input  logic             mem_rdy,
`endif
    output logic             PCWre,
    output logic [1:0]       PCSrc,
    output logic             IRWre,
    output logic             RegWre,
    output logic [1:0]       RegDst,
    output logic             WrRegDSrc,
    output logic             ALUSrcB,
    output logic             ExtSel,
    output logic [2:0]       ALUOp,
    output logic             mRD,
    output logic             mWR,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b010000;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    state_t cur, nxt;
    logic   halt_q, rdy, is_r, is_imm, is_alu, is_ls, is_br, is_jmp, is_unk, is_halt;

`ifdef MCTRL_MEMWAIT_EN
    assign rdy = mem_rdy;
`else
    assign rdy = 1'b1;
`endif

    assign is_r    = op == OP_ADD || op == OP_SUB;
    assign is_imm  = op == OP_ADDIU || op == OP_ORI;
    assign is_alu  = is_r || is_imm;
    assign is_ls   = op == OP_LW || op == OP_SW;
    assign is_br   = op == OP_BEQ || op == OP_BNE;
    assign is_jmp  = op == OP_J || op == OP_JR || op == OP_JAL;
    assign is_halt = op == HALT_OP;
    assign is_unk  = !(is_alu || is_ls || is_br || is_jmp);
    assign state   = cur;
    // halted shows as soon as HALT is decoded and then sticks via halt_q even if op moves
    assign halted  = halt_q || (cur == S_ID && is_halt);

    // next-state and datapath control decode; everything defaults to inactive
    always_comb begin
        nxt       = cur;
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = 3'b000;
        mRD       = 1'b0;
        mWR       = 1'b0;
        case (cur)
            S_IF: begin
                IRWre = 1'b1;
                nxt   = rdy ? S_ID : S_IF;
            end
            S_ID: if (!halted) begin
                nxt    = is_alu ? S_EXE_AL : is_ls ? S_EXE_LS : is_br ? S_EXE_BR : S_IF;
                PCWre  = is_jmp || is_unk;
                PCSrc  = op == OP_JR ? 2'b10 : (op == OP_J || op == OP_JAL) ? 2'b11 : 2'b00;
                RegWre = op == OP_JAL;
                RegDst = op == OP_JAL ? 2'b10 : 2'b00;
            end
            S_EXE_AL: begin
                ALUSrcB = is_imm;
                ExtSel  = op == OP_ADDIU;
                ALUOp   = op == OP_SUB ? 3'b001 : op == OP_ORI ? 3'b011 : 3'b000;
                nxt     = S_WB_AL;
            end
            S_EXE_LS: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                nxt     = S_MEM;
            end
            S_MEM: begin
                mRD   = op == OP_LW;
                mWR   = op == OP_SW;
                PCWre = op == OP_SW && rdy;
                nxt   = !rdy ? S_MEM : op == OP_LW ? S_WB_LD : S_IF;
            end
            S_WB_LD: begin
                RegWre    = 1'b1;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
                nxt       = S_IF;
            end
            S_EXE_BR: begin
                ALUOp  = 3'b001;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                PCSrc  = ((op == OP_BEQ && zero) || (op == OP_BNE && !zero)) ? 2'b01 : 2'b00;
                nxt    = S_IF;
            end
            S_WB_AL: begin
                RegWre = 1'b1;
                RegDst = is_r ? 2'b01 : 2'b00;
                PCWre  = 1'b1;
                nxt    = S_IF;
            end
            default: nxt = S_IF;
        endcase
    end

    // state register; reset abandons any instruction in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) cur <= S_IF;
        else      cur <= nxt;
    end

    // sticky halt flag, cleared only by reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                        halt_q <= 1'b0;
        else if (cur == S_ID && is_halt) halt_q <= 1'b1;
    end

    // retired-instruction counter, one count per PC commit, wraps naturally
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)       retired <= '0;
        else if (PCWre) retired <= retired + CNT_W'(1);
    end
endmodule
